// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - ALU opcodes, operand-select encodings and ID/EX payload type
package riscv_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLL  = 4'b0010,
        ALU_SLT  = 4'b0011,
        ALU_SLTU = 4'b0100,
        ALU_XOR  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_OR   = 4'b1000,
        ALU_AND  = 4'b1001,
        ALU_LUI  = 4'b1110
    } alu_op_e;

    typedef enum logic [1:0] {
        SRC1_RS1  = 2'b00,
        SRC1_PC   = 2'b01,
        SRC1_ZERO = 2'b10
    } src1_sel_e;

    typedef enum logic [1:0] {
        SRC2_RS2  = 2'b00,
        SRC2_IMM  = 2'b01,
        SRC2_FOUR = 2'b10
    } src2_sel_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [3:0]  alu_ctrl;
        src1_sel_e   src1_sel;
        src2_sel_e   src2_sel;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
    } id_ex_t;

endpackage

// File: rtl/fwd_unit.sv
// rtl/fwd_unit.sv - MEM/WB operand bypass for one source register
module fwd_unit #(
    parameter bit FWD_EN = 1'b1
) (
    input  logic [4:0]  rs_addr,
    input  logic [31:0] rs_data,
    input  logic        mem_fwd_en,
    input  logic [4:0]  mem_fwd_rd,
    input  logic [31:0] mem_fwd_data,
    input  logic        wb_fwd_en,
    input  logic [4:0]  wb_fwd_rd,
    input  logic [31:0] wb_fwd_data,
    output logic [31:0] fwd_data
);

    logic mem_hit;
    logic wb_hit;

    // x0 is hardwired to zero, so a write to it must never be bypassed
    assign mem_hit = FWD_EN && mem_fwd_en && (mem_fwd_rd == rs_addr) && (rs_addr != 5'd0);
    assign wb_hit  = FWD_EN && wb_fwd_en  && (wb_fwd_rd  == rs_addr) && (rs_addr != 5'd0);

    always_comb begin
        fwd_data = rs_data;
        if (mem_hit) begin
            fwd_data = mem_fwd_data;
        end else if (wb_hit) begin
            fwd_data = wb_fwd_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with hazard detection and operand bypass
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter bit FWD_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_rs1_data,
    input  logic [31:0] id_rs2_data,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic [4:0]  id_rd_addr,
    input  logic [3:0]  id_alu_ctrl,
    input  logic [1:0]  id_src1_sel,
    input  logic [1:0]  id_src2_sel,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        id_mem_write,
    input  logic        stall,
    input  logic        flush,
    input  logic        mem_fwd_en,
    input  logic [4:0]  mem_fwd_rd,
    input  logic [31:0] mem_fwd_data,
    input  logic        wb_fwd_en,
    input  logic [4:0]  wb_fwd_rd,
    input  logic [31:0] wb_fwd_data,
    output logic [31:0] alu_src1,
    output logic [31:0] alu_src2,
    output logic [3:0]  alu_ctrl,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_store_data,
    output logic [4:0]  ex_rd_addr,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        load_use_stall
);

    id_ex_t      ex_q;
    id_ex_t      id_next;
    logic [31:0] rs1_fwd;
    logic [31:0] rs2_fwd;

    always_comb begin
        id_next           = '0;
        id_next.valid     = id_valid;
        id_next.pc        = id_pc;
        id_next.rs1_addr  = id_rs1_addr;
        id_next.rs2_addr  = id_rs2_addr;
        id_next.rd_addr   = id_rd_addr;
        id_next.rs1_data  = id_rs1_data;
        id_next.rs2_data  = id_rs2_data;
        id_next.imm       = id_imm;
        id_next.alu_ctrl  = id_alu_ctrl;
        id_next.src1_sel  = src1_sel_e'(id_src1_sel);
        id_next.src2_sel  = src2_sel_e'(id_src2_sel);
        id_next.reg_write = id_reg_write;
        id_next.mem_read  = id_mem_read;
        id_next.mem_write = id_mem_write;
    end

    assign load_use_stall = ex_q.valid && ex_q.mem_read && (ex_q.rd_addr != 5'd0) && id_valid &&
                            ((id_rs1_addr == ex_q.rd_addr) || (id_rs2_addr == ex_q.rd_addr));

    // A bubble is an all-zero payload, identical to the reset image
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ex_q <= '0;
        end else if (stall) begin
            ex_q.rs1_data <= rs1_fwd;
            ex_q.rs2_data <= rs2_fwd;
        end else if (load_use_stall) begin
            ex_q <= '0;
        end else begin
            ex_q <= id_next;
        end
    end

    fwd_unit #(.FWD_EN(FWD_EN)) u_fwd_rs1 (
        .rs_addr      (ex_q.rs1_addr),
        .rs_data      (ex_q.rs1_data),
        .mem_fwd_en   (mem_fwd_en),
        .mem_fwd_rd   (mem_fwd_rd),
        .mem_fwd_data (mem_fwd_data),
        .wb_fwd_en    (wb_fwd_en),
        .wb_fwd_rd    (wb_fwd_rd),
        .wb_fwd_data  (wb_fwd_data),
        .fwd_data     (rs1_fwd)
    );

    fwd_unit #(.FWD_EN(FWD_EN)) u_fwd_rs2 (
        .rs_addr      (ex_q.rs2_addr),
        .rs_data      (ex_q.rs2_data),
        .mem_fwd_en   (mem_fwd_en),
        .mem_fwd_rd   (mem_fwd_rd),
        .mem_fwd_data (mem_fwd_data),
        .wb_fwd_en    (wb_fwd_en),
        .wb_fwd_rd    (wb_fwd_rd),
        .wb_fwd_data  (wb_fwd_data),
        .fwd_data     (rs2_fwd)
    );

    always_comb begin
        case (ex_q.src1_sel)
            SRC1_RS1: alu_src1 = rs1_fwd;
            SRC1_PC:  alu_src1 = ex_q.pc;
            default:  alu_src1 = 32'd0;
        endcase
        case (ex_q.src2_sel)
            SRC2_RS2:  alu_src2 = rs2_fwd;
            SRC2_IMM:  alu_src2 = ex_q.imm;
            SRC2_FOUR: alu_src2 = 32'd4;
            default:   alu_src2 = 32'd0;
        endcase
    end

    assign alu_ctrl      = ex_q.alu_ctrl;
    assign ex_valid      = ex_q.valid;
    assign ex_pc         = ex_q.pc;
    assign ex_store_data = rs2_fwd;
    assign ex_rd_addr    = ex_q.rd_addr;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0;
    logic [31:0] id_pc = '0, id_rs1_data = '0, id_rs2_data = '0, id_imm = '0;
    logic [4:0]  id_rs1_addr = '0, id_rs2_addr = '0, id_rd_addr = '0;
    logic [3:0]  id_alu_ctrl = '0;
    logic [1:0]  id_src1_sel = '0, id_src2_sel = '0;
    logic        id_reg_write = 1'b0, id_mem_read = 1'b0, id_mem_write = 1'b0;
    logic        stall = 1'b0, flush = 1'b0;
    logic        mem_fwd_en = 1'b0, wb_fwd_en = 1'b0;
    logic [4:0]  mem_fwd_rd = '0, wb_fwd_rd = '0;
    logic [31:0] mem_fwd_data = '0, wb_fwd_data = '0;
    logic [31:0] alu_src1, alu_src2, ex_pc, ex_store_data;
    logic [3:0]  alu_ctrl;
    logic [4:0]  ex_rd_addr;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.FWD_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_alu_ctrl(id_alu_ctrl), .id_src1_sel(id_src1_sel), .id_src2_sel(id_src2_sel),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .stall(stall), .flush(flush),
        .mem_fwd_en(mem_fwd_en), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
        .wb_fwd_en(wb_fwd_en), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_ctrl(alu_ctrl),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .load_use_stall(load_use_stall)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [31:0] pc, input logic [4:0] rs1, input logic [31:0] d1,
                          input logic [4:0] rs2, input logic [31:0] d2, input logic [4:0] rd,
                          input logic [31:0] imm, input logic [3:0] ctrl, input logic [1:0] s1,
                          input logic [1:0] s2, input logic rw, input logic mr, input logic mw);
        id_valid = 1'b1;   id_pc = pc;        id_rs1_addr = rs1; id_rs1_data = d1;
        id_rs2_addr = rs2; id_rs2_data = d2;  id_rd_addr = rd;   id_imm = imm;
        id_alu_ctrl = ctrl; id_src1_sel = s1; id_src2_sel = s2;
        id_reg_write = rw; id_mem_read = mr;  id_mem_write = mw;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_id(32'h40, 5'd1, 32'h99, 5'd2, 32'h88, 5'd3, 32'h77, 4'h3, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        n_cmp++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", ex_valid); end
        n_cmp++; if (alu_src1 !== 32'h0) begin n_fail++; $display("FAIL reset_src1: got %h want 0", alu_src1); end
        n_cmp++; if (alu_src2 !== 32'h0) begin n_fail++; $display("FAIL reset_src2: got %h want 0", alu_src2); end
        n_cmp++; if (alu_ctrl !== 4'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h want 0", alu_ctrl); end
        n_cmp++; if (ex_store_data !== 32'h0) begin n_fail++; $display("FAIL reset_store: got %h want 0", ex_store_data); end
        n_cmp++; if (load_use_stall !== 1'b0) begin n_fail++; $display("FAIL reset_lus: got %b want 0", load_use_stall); end
        rst = 1'b0;
    endtask

    task automatic test_operand_select();
        set_id(32'h100, 5'd1, 32'h11, 5'd2, 32'h22, 5'd4, 32'h30, 4'h5, 2'd0, 2'd1, 1'b1, 1'b0, 1'b0);
        tick();
        n_cmp++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL sel_valid: got %b want 1", ex_valid); end
        n_cmp++; if (ex_pc !== 32'h100) begin n_fail++; $display("FAIL sel_pc: got %h want 100", ex_pc); end
        n_cmp++; if (alu_src1 !== 32'h11) begin n_fail++; $display("FAIL sel_rs1: got %h want 11", alu_src1); end
        n_cmp++; if (alu_src2 !== 32'h30) begin n_fail++; $display("FAIL sel_imm: got %h want 30", alu_src2); end
        n_cmp++; if (ex_store_data !== 32'h22) begin n_fail++; $display("FAIL sel_store: got %h want 22", ex_store_data); end
        n_cmp++; if (alu_ctrl !== 4'h5) begin n_fail++; $display("FAIL sel_ctrl: got %h want 5", alu_ctrl); end
        n_cmp++; if (ex_rd_addr !== 5'd4) begin n_fail++; $display("FAIL sel_rd: got %0d want 4", ex_rd_addr); end
        set_id(32'h200, 5'd1, 32'h11, 5'd2, 32'h22, 5'd4, 32'h30, 4'h6, 2'd1, 2'd2, 1'b1, 1'b0, 1'b0);
        tick();
        n_cmp++; if (alu_src1 !== 32'h200) begin n_fail++; $display("FAIL sel_pcsrc: got %h want 200", alu_src1); end
        n_cmp++; if (alu_src2 !== 32'h4) begin n_fail++; $display("FAIL sel_four: got %h want 4", alu_src2); end
        set_id(32'h204, 5'd1, 32'h11, 5'd2, 32'h22, 5'd4, 32'h30, 4'h6, 2'd2, 2'd3, 1'b1, 1'b0, 1'b0);
        tick();
        n_cmp++; if (alu_src1 !== 32'h0) begin n_fail++; $display("FAIL sel_zero: got %h want 0", alu_src1); end
        n_cmp++; if (alu_src2 !== 32'h0) begin n_fail++; $display("FAIL sel_src2_11: got %h want 0", alu_src2); end
        n_cmp++; if (ex_store_data !== 32'h22) begin n_fail++; $display("FAIL sel_store_any: got %h want 22", ex_store_data); end
        set_id(32'h208, 5'd1, 32'h11, 5'd2, 32'h22, 5'd4, 32'h30, 4'h6, 2'd3, 2'd0, 1'b1, 1'b0, 1'b0);
        tick();
        n_cmp++; if (alu_src1 !== 32'h0) begin n_fail++; $display("FAIL sel_src1_11: got %h want 0", alu_src1); end
    endtask

    task automatic test_fwd_priority();
        set_id(32'h300, 5'd5, 32'h1, 5'd6, 32'h2, 5'd8, 32'h0, 4'h0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
        tick();
        mem_fwd_en = 1'b1; mem_fwd_rd = 5'd5; mem_fwd_data = 32'hAAAA0000;
        wb_fwd_en  = 1'b1; wb_fwd_rd  = 5'd5; wb_fwd_data  = 32'h12345678;
        #1;
        n_cmp++; if (alu_src1 !== 32'hAAAA0000) begin n_fail++; $display("FAIL fwd_mem_prio: got %h want aaaa0000", alu_src1); end
        mem_fwd_en = 1'b0;
        #1;
        n_cmp++; if (alu_src1 !== 32'h12345678) begin n_fail++; $display("FAIL fwd_wb: got %h want 12345678", alu_src1); end
        wb_fwd_rd = 5'd6;
        #1;
        n_cmp++; if (alu_src1 !== 32'h1) begin n_fail++; $display("FAIL fwd_none_rs1: got %h want 1", alu_src1); end
        n_cmp++; if (alu_src2 !== 32'h12345678) begin n_fail++; $display("FAIL fwd_wb_rs2: got %h want 12345678", alu_src2); end
        n_cmp++; if (ex_store_data !== 32'h12345678) begin n_fail++; $display("FAIL fwd_store: got %h want 12345678", ex_store_data); end
        wb_fwd_en = 1'b0;
    endtask

    task automatic test_x0();
        set_id(32'h400, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 4'h0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
        tick();
        mem_fwd_en = 1'b1; mem_fwd_rd = 5'd0; mem_fwd_data = 32'hFFFFFFFF;
        wb_fwd_en  = 1'b1; wb_fwd_rd  = 5'd0; wb_fwd_data  = 32'hFFFFFFFF;
        #1;
        n_cmp++; if (alu_src1 !== 32'h0) begin n_fail++; $display("FAIL x0_fwd_rs1: got %h want 0", alu_src1); end
        n_cmp++; if (ex_store_data !== 32'h0) begin n_fail++; $display("FAIL x0_fwd_rs2: got %h want 0", ex_store_data); end
        n_cmp++; if (load_use_stall !== 1'b0) begin n_fail++; $display("FAIL x0_load_use: got %b want 0", load_use_stall); end
        mem_fwd_en = 1'b0; wb_fwd_en = 1'b0;
    endtask

    task automatic test_load_use();
        set_id(32'h500, 5'd1, 32'h1000, 5'd0, 32'h0, 5'd7, 32'h4, 4'h0, 2'd0, 2'd1, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(32'h504, 5'd8, 32'h10, 5'd7, 32'hDEAD, 5'd9, 32'h0, 4'h0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
        #1;
        n_cmp++; if (load_use_stall !== 1'b1) begin n_fail++; $display("FAIL lu_detect: got %b want 1", load_use_stall); end
        tick();
        n_cmp++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL lu_bubble_valid: got %b want 0", ex_valid); end
        n_cmp++; if (ex_mem_read !== 1'b0) begin n_fail++; $display("FAIL lu_bubble_mr: got %b want 0", ex_mem_read); end
        n_cmp++; if (load_use_stall !== 1'b0) begin n_fail++; $display("FAIL lu_release: got %b want 0", load_use_stall); end
        tick();
        wb_fwd_en = 1'b1; wb_fwd_rd = 5'd7; wb_fwd_data = 32'h42;
        #1;
        n_cmp++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL lu_enter_valid: got %b want 1", ex_valid); end
        n_cmp++; if (ex_rd_addr !== 5'd9) begin n_fail++; $display("FAIL lu_enter_rd: got %0d want 9", ex_rd_addr); end
        n_cmp++; if (alu_src2 !== 32'h42) begin n_fail++; $display("FAIL lu_fwd_load: got %h want 42", alu_src2); end
        n_cmp++; if (alu_src1 !== 32'h10) begin n_fail++; $display("FAIL lu_rs1: got %h want 10", alu_src1); end
        wb_fwd_en = 1'b0;
    endtask

    task automatic test_stall_recapture();
        set_id(32'h600, 5'd3, 32'h7, 5'd0, 32'h0, 5'd10, 32'h0, 4'h0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
        tick();
        stall = 1'b1;
        set_id(32'h700, 5'd1, 32'h9, 5'd2, 32'h9, 5'd11, 32'h0, 4'h2, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
        wb_fwd_en = 1'b1; wb_fwd_rd = 5'd3; wb_fwd_data = 32'h55;
        #1;
        n_cmp++; if (alu_src1 !== 32'h55) begin n_fail++; $display("FAIL stall_c1: got %h want 55", alu_src1); end
        tick();
        wb_fwd_en = 1'b0;
        #1;
        n_cmp++; if (alu_src1 !== 32'h55) begin n_fail++; $display("FAIL stall_c2: got %h want 55", alu_src1); end
        n_cmp++; if (ex_pc !== 32'h600) begin n_fail++; $display("FAIL stall_hold_pc: got %h want 600", ex_pc); end
        tick();
        n_cmp++; if (alu_src1 !== 32'h55) begin n_fail++; $display("FAIL stall_c3: got %h want 55", alu_src1); end
        n_cmp++; if (ex_rd_addr !== 5'd10) begin n_fail++; $display("FAIL stall_hold_rd: got %0d want 10", ex_rd_addr); end
        stall = 1'b0;
    endtask

    task automatic test_flush_stall();
        set_id(32'h800, 5'd1, 32'h1, 5'd2, 32'h2, 5'd11, 32'h0, 4'h9, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1);
        tick();
        n_cmp++; if (ex_mem_write !== 1'b1) begin n_fail++; $display("FAIL flush_pre_mw: got %b want 1", ex_mem_write); end
        flush = 1'b1; stall = 1'b1;
        tick();
        flush = 1'b0; stall = 1'b0;
        #1;
        n_cmp++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", ex_valid); end
        n_cmp++; if (ex_reg_write !== 1'b0) begin n_fail++; $display("FAIL flush_rw: got %b want 0", ex_reg_write); end
        n_cmp++; if (ex_mem_write !== 1'b0) begin n_fail++; $display("FAIL flush_mw: got %b want 0", ex_mem_write); end
        n_cmp++; if (alu_ctrl !== 4'h0) begin n_fail++; $display("FAIL flush_ctrl: got %h want 0", alu_ctrl); end
    endtask

    task automatic test_rst_over_stall();
        set_id(32'h900, 5'd1, 32'h1, 5'd2, 32'h2, 5'd12, 32'h0, 4'h1, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0);
        tick();
        stall = 1'b1; rst = 1'b1;
        tick();
        stall = 1'b0; rst = 1'b0;
        #1;
        n_cmp++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL rst_stall_valid: got %b want 0", ex_valid); end
        n_cmp++; if (ex_pc !== 32'h0) begin n_fail++; $display("FAIL rst_stall_pc: got %h want 0", ex_pc); end
    endtask

    initial begin
        test_reset();
        test_operand_select();
        test_fwd_priority();
        test_x0();
        test_load_use();
        test_stall_recapture();
        test_flush_stall();
        test_rst_over_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: FWD_EN, default 1, 1 enables MEM/WB operand forwarding, 0 always uses register-file data.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 id_valid, id_pc[31:0], id_rs1_data[31:0], id_rs2_data[31:0], id_imm[31:0]  input  decoded instruction payload.
REQ-005 id_rs1_addr[4:0], id_rs2_addr[4:0], id_rd_addr[4:0]  input  register indices.
REQ-006 id_alu_ctrl[3:0], id_src1_sel[1:0] (RS1/PC/ZERO), id_src2_sel[1:0] (RS2/IMM/FOUR), id_reg_write, id_mem_read, id_mem_write  input  control.
REQ-007 stall  input  1  hold EX contents; flush  input  1  kill EX contents.
REQ-008 mem_fwd_en, mem_fwd_rd[4:0], mem_fwd_data[31:0], wb_fwd_en, wb_fwd_rd[4:0], wb_fwd_data[31:0]  input  forwarding sources.
REQ-009 alu_src1[31:0], alu_src2[31:0], alu_ctrl[3:0]  output  ALU operands/opcode.
REQ-010 ex_valid, ex_pc[31:0], ex_store_data[31:0], ex_rd_addr[4:0], ex_reg_write, ex_mem_read, ex_mem_write  output  EX payload.
REQ-011 load_use_stall  output  1  upstream must hold ID.

Function
REQ-012 Stage register SHALL load all id_* fields on a clock edge when !stall && !flush && !load_use_stall.
REQ-013 load_use_stall SHALL be combinational: ex_valid && ex_mem_read && ex_rd_addr!=0 && id_valid && (id_rs1_addr==ex_rd_addr || id_rs2_addr==ex_rd_addr).
REQ-014 load_use_stall && !stall && !flush SHALL load a bubble: ex_valid=0, ex_reg_write=0, ex_mem_read=0, ex_mem_write=0, alu_ctrl=0000.
REQ-015 flush SHALL load a bubble next cycle; flush wins over stall and load_use_stall when simultaneous.
REQ-016 stall && !flush SHALL hold all fields, except rs1/rs2 data SHALL be re-captured from the forwarded values each cycle so WB results retiring during the stall are not lost.
REQ-017 Forwarded rs1 (rs2 same): if FWD_EN && mem_fwd_en && mem_fwd_rd==rs1 && rs1!=0 -> mem_fwd_data; else if FWD_EN && wb_fwd_en && wb_fwd_rd==rs1 && rs1!=0 -> wb_fwd_data; else registered data. MEM priority over WB.
REQ-018 alu_src1 SHALL be forwarded rs1, ex_pc, or 0 per src1_sel; alu_src2 forwarded rs2, imm, or 32'd4 per src2_sel; sel 11 SHALL yield 0.
REQ-019 ex_store_data SHALL always equal forwarded rs2 regardless of src2_sel.
REQ-020 alu_ctrl SHALL pass registered id_alu_ctrl unchanged; operand/output latency is 1 cycle from ID capture, forwarding path 0 cycles.
REQ-021 Register x0 index SHALL never match for forwarding or load-use.

Reset
REQ-022 rst on clock edge SHALL clear every register: ex_valid=0, all controls 0, ex_pc=0, data/imm=0, rd=0, alu_ctrl=0000; rst dominates stall/flush.
REQ-023 With the cleared state, alu_src1=alu_src2=0, ex_store_data=0, load_use_stall=0 after reset.

Structure
REQ-024 Package riscv_pkg SHALL hold ALU opcode constants (4-bit, 0000 ADD..1110 LUI copy), src1_sel/src2_sel enums, and the ID/EX payload struct.
REQ-025 One sub-module fwd_unit SHALL implement REQ-017/REQ-021, instantiated twice (rs1, rs2).

Verification
REQ-026 Reset: assert rst 2 cycles with id_valid=1 -> ex_valid=0, alu_src1=alu_src2=0, alu_ctrl=0000.
REQ-027 Forward priority: rs1=5, mem_fwd rd=5 data=0xAAAA0000, wb_fwd rd=5 data=0x12345678 -> alu_src1=0xAAAA0000; drop mem_fwd_en -> 0x12345678.
REQ-028 x0: rs1=0, mem_fwd rd=0 data=0xFFFFFFFF, id_rs1_data=0 -> alu_src1=0.
REQ-029 Load-use: EX lw rd=7, ID add rs2=7 -> load_use_stall=1, next cycle ex_valid=0, then add enters with WB-forwarded load value 0x00000042.
REQ-030 Stall re-capture: EX holds rs1=3, stall=1 for 3 cycles, wb_fwd rd=3 data=0x55 in cycle 1 only -> alu_src1=0x55 in cycles 2-3.
REQ-031 Flush+stall same cycle -> next ex_valid=0, ex_reg_write=0, ex_mem_write=0.
